lcd_cmd_arbiter: RTL and testbench
==================================

Name: lcd_cmd_arbiter

Overview:
- Shares one LCD character controller among NREQ command sources.
- The controller uses an enable/busy handshake with a 10-bit {rs, rw, data[7:0]} command bus.
- Round-robin arbitration. Latches the winner's command, drives lcd_enable until the controller acknowledges with busy, then waits for busy to fall before issuing the next command.
- Sits between firmware/UI command producers and the LCD controller.

Parameters:
- NREQ, 3, number of requesters (2..4).
- TIMEOUT, 1023, max cycles in ISSUE or WAIT_DONE before abort. Used only with the optional feature.
- TW, 10, timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester command request, level.
- req_bus  input  NREQ*10  packed commands; slice k = req_bus[10k+9:10k] = {rs, rw, data[7:0]}.
- ack  output  NREQ  one-cycle pulse to requester k when its command is accepted.
- lcd_busy  input  1  busy from LCD controller.
- lcd_enable  output  1  command strobe to LCD controller.
- lcd_bus  output  10  latched command to LCD controller.
- grant_id  output  2  index of the current or last granted requester.
- active  output  1  high in any state other than IDLE.
- timeout_err  output  1  one-cycle abort pulse; constant 0 without the optional feature.

Behaviour:
- Reset (sync, at posedge with rst=1):
  - State IDLE.
  - lcd_enable=0, lcd_bus=0, ack=0, grant_id=0, active=0, timeout_err=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has first priority.
- Reset mid-operation: same result. lcd_enable is low the cycle after rst is sampled; the pending command is dropped with no ack.
- IDLE:
  - If lcd_busy=0 and any req=1: search indices ptr+1, ptr+2, ... mod NREQ; first asserted index k wins.
  - Register lcd_bus<=slice k, grant_id<=k, lcd_enable<=1, go to ISSUE.
  - Latency: req sampled at edge t drives lcd_enable=1 after edge t (visible cycle t+1).
  - If lcd_busy=1 (controller still initializing or executing), no grant is made.
- ISSUE:
  - Hold lcd_enable=1 and lcd_bus stable until lcd_busy=1 is sampled.
  - Then: lcd_enable<=0, ack[k]<=1 for exactly one cycle, ptr<=k, go to WAIT_DONE.
- WAIT_DONE:
  - lcd_enable=0. When lcd_busy=0 is sampled, go to IDLE.
  - A new grant can occur on the IDLE cycle after that, so there is at least one IDLE cycle between commands.
- Commitment rules:
  - Once latched, a command is committed. If the requester drops req before ack, the command is still issued and ack still pulses.
  - A requester holding req after ack requests a new command. It competes with lower round-robin priority than the others.
- Fairness: with all NREQ requesters continuously asserted, grants rotate 0,1,2,0,...
- Only one ack bit is ever high at a time; ack is never asserted in IDLE.
- Non-granted req slices are ignored; their changes have no effect.

Optional Feature:
- Macro: LCD_CMD_ARBITER_TIMEOUT_EN.
- When defined:
  - A TW-bit counter clears on entry to ISSUE and WAIT_DONE and increments each cycle spent in those states.
  - If it reaches TIMEOUT while in ISSUE: lcd_enable<=0, no ack, timeout_err pulses 1 cycle, ptr<=k, go to IDLE.
  - If it reaches TIMEOUT while in WAIT_DONE: timeout_err pulses, go to IDLE. The ack was already given.
- When undefined: no counter; the block waits indefinitely; timeout_err is tied 0.

Test Plan:
- Reset then single request: rst 2 cycles, lcd_busy=0, req=3'b001, req_bus slice0=10'h230. Required: lcd_enable=1 with lcd_bus=10'h230 one cycle after req is sampled. Controller raises busy 3 cycles later; lcd_enable falls and ack=3'b001 for 1 cycle. busy falls; active=0 on the next cycle.
- Round-robin: req=3'b111 held, controller model busy for 5 cycles per command. Required: grant_id sequence 0,1,2,0,1,2; ack pulses in the same order; never two ack bits high at once.
- Busy at start: lcd_busy=1 for 200 cycles with req=3'b010. Required: lcd_enable stays 0 and active=0 throughout. Grant to 1 occurs on the cycle after busy is sampled low.
- Request withdrawn: req[2] pulses for one cycle only, slice2=10'h101. Required: command still issued with lcd_bus=10'h101, ack[2] pulses, no reissue afterwards.
- Mid-operation reset: assert rst during WAIT_DONE with req=3'b011. Required: next cycle active=0, lcd_enable=0, ack=0. After release, requester 0 is granted first.
- Timeout (macro defined, TIMEOUT=20): lcd_busy held 0 after grant. Required: lcd_enable high for exactly 20 cycles, timeout_err one pulse, no ack. The next grant goes to the next requester in rotation. Without the macro, lcd_enable stays high indefinitely.

Source files
------------

// File: rtl/lcd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_cmd_arbiter
//
// Shares one LCD character controller between NREQ command sources.
// Requests are granted round-robin. The winner's {rs, rw, data[7:0]} command
// is latched and presented on lcd_bus with lcd_enable held high until the
// controller answers with lcd_busy. The arbiter then waits for lcd_busy to
// drop before it returns to IDLE, where the next grant can be made.
//
// Optional feature (macro LCD_CMD_ARBITER_TIMEOUT_EN):
//   A TW-bit counter limits the time spent in ISSUE and WAIT_DONE to TIMEOUT
//   cycles. On expiry the arbiter aborts to IDLE and pulses timeout_err.
//   Without the macro there is no counter and timeout_err is tied low.
//
// Parameters:
//   NREQ     number of requesters (2..4)
//   TIMEOUT  abort limit in cycles (timeout feature only)
//   TW       width of the timeout counter, must hold TIMEOUT
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   req          per-requester level request
//   req_bus      packed commands, slice k = req_bus[10k+9:10k]
//   ack          one-cycle acceptance pulse to the granted requester
//   lcd_busy     busy from the LCD controller
//   lcd_enable   command strobe to the LCD controller
//   lcd_bus      latched command to the LCD controller
//   grant_id     index of the current or last granted requester
//   active       high whenever the arbiter is not IDLE
//   timeout_err  one-cycle abort pulse (0 without the timeout feature)
// ---------------------------------------------------------------------------
module lcd_cmd_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*10-1:0]   req_bus,
    output logic [NREQ-1:0]      ack,
    input  logic                 lcd_busy,
    output logic                 lcd_enable,
    output logic [9:0]           lcd_bus,
    output logic [1:0]           grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    // Catch illegal configurations at elaboration.
    if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1 || TIMEOUT >= (1 << TW)) begin : g_bad_cfg
        $error("lcd_cmd_arbiter: illegal NREQ/TIMEOUT/TW combination");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            en_d;
    logic [9:0]      bus_d;
    logic [1:0]      gid_d;
    logic [NREQ-1:0] ack_d;

    logic            win_found;
    logic [1:0]      win_idx;

`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            to_q, to_d;
    logic            to_hit;

    // The counter holds the number of completed cycles in the current state,
    // so the edge that would make it reach TIMEOUT is the abort edge.
    assign to_hit = (cnt_q == TW'(TIMEOUT - 1));
`endif

    // Round-robin search: start just after the last winner and take the first
    // asserted request. The last winner itself is examined last.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = 2'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        en_d    = lcd_enable;
        bus_d   = lcd_bus;
        gid_d   = grant_id;
        ack_d   = '0;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A busy controller is still initialising or executing:
                // never hand it a new command.
                if (!lcd_busy && win_found) begin
                    bus_d   = req_bus[int'(win_idx)*10 +: 10];
                    gid_d   = win_idx;
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            S_ISSUE: begin
                if (lcd_busy) begin
                    // Controller has taken the command: release the strobe,
                    // acknowledge, and demote this requester in the rotation.
                    en_d          = 1'b0;
                    ack_d[grant_id] = 1'b1;
                    ptr_d         = grant_id;
                    state_d       = S_WAIT_DONE;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
                else if (to_hit) begin
                    // Abandon the command without ack; the requester still
                    // loses its turn so a stuck source cannot starve others.
                    en_d    = 1'b0;
                    to_d    = 1'b1;
                    ptr_d   = grant_id;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end

            S_WAIT_DONE: begin
                if (!lcd_busy) begin
                    state_d = S_IDLE;
                end
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
                else if (to_hit) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 2'(NREQ - 1);
            lcd_enable <= 1'b0;
            lcd_bus    <= '0;
            grant_id   <= '0;
            ack        <= '0;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
            cnt_q      <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lcd_enable <= en_d;
            lcd_bus    <= bus_d;
            grant_id   <= gid_d;
            ack        <= ack_d;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
            cnt_q      <= cnt_d;
            to_q       <= to_d;
`endif
        end
    end

    assign active = (state_q != S_IDLE);

`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_arbiter
//
// Directed bench for lcd_cmd_arbiter (NREQ=3). A transaction-level model of
// the arbiter tracks, per clock, which command is outstanding and what the
// outputs must be; a compare process checks every output against it on each
// falling edge. Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 20;
    localparam int TW   = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*10-1:0] req_bus = '0;
    logic            lcd_busy = 1'b0;
    logic [NREQ-1:0] ack;
    logic            lcd_enable;
    logic [9:0]      lcd_bus;
    logic [1:0]      grant_id;
    logic            active;
    logic            timeout_err;

    lcd_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .TW(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_bus(req_bus), .ack(ack),
        .lcd_busy(lcd_busy), .lcd_enable(lcd_enable), .lcd_bus(lcd_bus),
        .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // busy_cmd: -1 no command outstanding, else the requester whose command
    // is outstanding; handed: controller has accepted it.
    int          m_cmd = -1;
    bit          m_handed = 0;
    int          m_last = NREQ - 1;
    int          m_cycles = 0;
    logic        m_en = 0;
    logic [9:0]  m_bus = '0;
    int          m_gid = 0;
    logic [2:0]  m_ack = '0;
    logic        m_to = 0;
    bit          m_ok = 0;
    int          m_w;

    function automatic int rr_pick(input int last, input logic [2:0] r);
        for (int i = 1; i <= NREQ; i++)
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cmd = -1; m_handed = 0; m_last = NREQ - 1; m_cycles = 0;
            m_en = 0; m_bus = '0; m_gid = 0; m_ack = '0; m_to = 0; m_ok = 1;
        end else begin
            m_ack = '0;
            m_to  = 0;
            if (m_cmd < 0) begin
                m_w = rr_pick(m_last, req);
                if (!lcd_busy && m_w >= 0) begin
                    m_cmd = m_w; m_handed = 0; m_cycles = 0;
                    m_gid = m_w; m_bus = req_bus[m_w*10 +: 10]; m_en = 1;
                end
            end else if (!m_handed) begin
                if (lcd_busy) begin
                    m_handed = 1; m_cycles = 0; m_en = 0;
                    m_ack[m_cmd] = 1'b1; m_last = m_cmd;
                end else begin
                    m_cycles++;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
                    if (m_cycles >= TO) begin
                        m_en = 0; m_to = 1; m_last = m_cmd; m_cmd = -1;
                    end
`endif
                end
            end else begin
                if (!lcd_busy) begin
                    m_cmd = -1;
                end else begin
                    m_cycles++;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
                    if (m_cycles >= TO) begin
                        m_to = 1; m_cmd = -1;
                    end
`endif
                end
            end
        end
    end

    int ack_log[$];

    always @(negedge clk) begin
        if (m_ok) begin
            chk("lcd_enable", lcd_enable, m_en);
            chk("lcd_bus", lcd_bus, m_bus);
            chk("grant_id", grant_id, m_gid);
            chk("ack", ack, m_ack);
            chk("active", active, (m_cmd >= 0));
            chk("timeout_err", timeout_err, m_to);
            chk("ack_onehot", ($countones(ack) <= 1), 1);
            chk("ack_in_idle", (ack != '0 && !active), 0);
            if (ack != '0) ack_log.push_back(int'(grant_id));
        end
    end

    // ---------------- stimulus helpers ----------------
    bit auto_busy = 0;
    int bcnt = 0;

    // Advance one cycle; optionally play a controller that stays busy for
    // 5 cycles after seeing a strobe.
    task automatic step();
        @(negedge clk);
        if (auto_busy) begin
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) lcd_busy = 1'b0;
            end else if (lcd_enable && !lcd_busy) begin
                lcd_busy = 1'b1;
                bcnt = 5;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while ((active || lcd_busy) && c < 100) begin
            step();
            c++;
        end
        chk({tag, "_idle"}, active, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, ens, tos, aks, c;

        // ---- reset then single request ----
        req_bus[9:0] = 10'h230;
        step(); step();
        rst = 1'b0;
        chk("rst_enable", lcd_enable, 0);
        chk("rst_active", active, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ack", ack, 0);
        req = 3'b001;
        step();
        chk("t1_enable", lcd_enable, 1);
        chk("t1_bus", lcd_bus, 10'h230);
        chk("t1_active", active, 1);
        req = 3'b000;
        step(); step();
        chk("t1_hold", lcd_enable, 1);
        lcd_busy = 1'b1;
        step();
        chk("t1_ack", ack, 3'b001);
        chk("t1_en_fall", lcd_enable, 0);
        step();
        chk("t1_ack_once", ack, 3'b000);
        lcd_busy = 1'b0;
        step();
        chk("t1_done", active, 0);

        // ---- round robin ----
        rst = 1'b1; step(); rst = 1'b0;
        ack_log.delete();
        req_bus = {10'h233, 10'h122, 10'h011};
        req = 3'b111;
        auto_busy = 1;
        for (c = 0; c < 300 && ack_log.size() < 6; c++) step();
        req = 3'b000;
        chk("t2_ack_count", ack_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < ack_log.size()) chk("t2_order", ack_log[i], i % 3);
        wait_idle("t2");
        auto_busy = 0;

        // ---- busy at start ----
        rst = 1'b1; lcd_busy = 1'b1; req = 3'b010;
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (lcd_enable || active) bad++;
        end
        chk("t3_blocked", bad, 0);
        lcd_busy = 1'b0;
        step();
        chk("t3_enable", lcd_enable, 1);
        chk("t3_grant", grant_id, 1);
        chk("t3_bus", lcd_bus, 10'h122);
        req = 3'b000;
        lcd_busy = 1'b1;
        step();
        chk("t3_ack", ack, 3'b010);
        lcd_busy = 1'b0;
        wait_idle("t3");

        // ---- request withdrawn ----
        req_bus[29:20] = 10'h101;
        req = 3'b100;
        step();
        req = 3'b000;
        chk("t4_enable", lcd_enable, 1);
        chk("t4_bus", lcd_bus, 10'h101);
        chk("t4_grant", grant_id, 2);
        step();
        lcd_busy = 1'b1;
        step();
        chk("t4_ack", ack, 3'b100);
        lcd_busy = 1'b0;
        step();
        ens = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (lcd_enable) ens++;
        end
        chk("t4_no_reissue", ens, 0);

        // ---- reset during WAIT_DONE ----
        req = 3'b011;
        auto_busy = 1;
        c = 0;
        while (ack == '0 && c < 30) begin step(); c++; end
        chk("t5_reached_wait", (ack != '0), 1);
        rst = 1'b1;
        auto_busy = 0; bcnt = 0; lcd_busy = 1'b0;
        step();
        chk("t5_active", active, 0);
        chk("t5_enable", lcd_enable, 0);
        chk("t5_ack", ack, 0);
        rst = 1'b0;
        step();
        chk("t5_first_grant", grant_id, 0);
        chk("t5_first_enable", lcd_enable, 1);

        // ---- controller never answers ----
        req = 3'b000;
        ens = 1; tos = 0; aks = 0;
`ifdef LCD_CMD_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 60; i++) begin
            step();
            if (lcd_enable) ens++;
            if (timeout_err) tos++;
            if (ack != '0) aks++;
        end
        chk("t6_enable_cycles", ens, TO);
        chk("t6_timeout_pulses", tos, 1);
        chk("t6_no_ack", aks, 0);
        req = 3'b011;
        step();
        chk("t6_next_grant", grant_id, 1);
        chk("t6_next_enable", lcd_enable, 1);
        req = 3'b000;
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (lcd_enable) ens++;
            if (timeout_err) tos++;
        end
        chk("t6_enable_held", ens, 101);
        chk("t6_no_timeout", tos, 0);
`endif
        lcd_busy = 1'b1;
        step();
        lcd_busy = 1'b0;
        wait_idle("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
